tt_sel_seq: RTL and testbench
=============================

TT_SEL_SEQ -- requirements
Module: tt_sel_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: width of the design-select address.
REQ-002 SHALL have parameter HALF_PER, default 2: clk cycles per half-period of every control pulse, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: a selection request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the sequencer accepts a request this cycle.
REQ-007 SHALL have port req_addr, input, ADDR_W bits: the target design address.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking completion of a selection.
REQ-009 SHALL have port busy, output, 1 bit: a sequence is in progress, including INIT.
REQ-010 SHALL have port cur_addr, output, ADDR_W bits: the currently selected address.
REQ-011 SHALL have port ctrl_sel_rst_n, output, 1 bit: selector counter reset, active-low, driven to the controller.
REQ-012 SHALL have port ctrl_sel_inc, output, 1 bit: selector increment strobe.
REQ-013 SHALL have port ctrl_ena, output, 1 bit: enable for the selected design.

Function
REQ-014 SHALL implement FSM states INIT, IDLE, DISABLE, RST_LO, RST_HI, INC_HI, INC_LO and DONE.
REQ-015 SHALL use a half-period timer so that every non-IDLE, non-DONE state lasts exactly HALF_PER cycles.
REQ-016 In INIT, ctrl_sel_rst_n SHALL be 0 for HALF_PER cycles, then the FSM SHALL go to IDLE with cur_addr=0.
REQ-017 In IDLE, req_ready SHALL be 1; in all other states req_ready SHALL be 0.
REQ-018 Acceptance SHALL occur on req_valid && req_ready; req_addr SHALL be latched on that edge, and the next state SHALL be DISABLE.
REQ-019 In DISABLE, ctrl_ena SHALL be 0; the next state SHALL be RST_LO (full path) or INC_HI (fast path, REQ-033).
REQ-020 In RST_LO, ctrl_sel_rst_n SHALL be 0.
REQ-021 In RST_HI, ctrl_sel_rst_n SHALL be 1.
REQ-022 The remaining-increment counter N SHALL be loaded with the latched address on the full path, or with the latched address minus cur_addr on the fast path.
REQ-023 From RST_HI, the FSM SHALL go to INC_HI if N>0, else to DONE.
REQ-024 In INC_HI, ctrl_sel_inc SHALL be 1, and N SHALL decrement on exit; in INC_LO, ctrl_sel_inc SHALL be 0.
REQ-025 From INC_LO, the FSM SHALL go to INC_HI if N>0, else to DONE.
REQ-026 DONE SHALL last 1 cycle: done=1, ctrl_ena=1, cur_addr SHALL be updated to the latched address, and the next state SHALL be IDLE.
REQ-027 ctrl_ena SHALL remain 1 in IDLE after any DONE and SHALL be 0 from reset until the first DONE.
REQ-028 Full-path latency, measured from the acceptance edge to the done cycle, SHALL be 3*HALF_PER + 2*N*HALF_PER + 1 cycles.
REQ-029 req_valid while busy SHALL be ignored and never queued; req_addr changes after acceptance SHALL have no effect.
REQ-030 req_addr=0 SHALL produce no ctrl_sel_inc pulses.
REQ-031 The counters SHALL be ADDR_W wide with no wrap-around; the fast-path subtraction SHALL be computed only when req_addr >= cur_addr.

Reset
REQ-032 While rst=1, outputs SHALL be: ctrl_sel_rst_n=0, ctrl_sel_inc=0, ctrl_ena=0, done=0, req_ready=0, busy=1, cur_addr=0, state=INIT, timer=0; assertion mid-sequence SHALL abort immediately to these values.

Configuration
REQ-033 With TT_SEL_SEQ_FASTINC_EN defined, a request with req_addr >= cur_addr SHALL skip RST_LO/RST_HI and issue only req_addr-cur_addr increments; with req_addr < cur_addr, it SHALL take the full path.
REQ-034 Without TT_SEL_SEQ_FASTINC_EN, every request SHALL take the full path, and no subtractor SHALL be synthesized.

Verification (HALF_PER=2 unless noted)
REQ-035 Release rst -> ctrl_sel_rst_n low 2 cycles, req_ready=1 on cycle 3, cur_addr=0, ctrl_ena=0.
REQ-036 Request addr=3 from idle (full path) -> 3 inc pulses each 2 high/2 low, done 19 cycles after acceptance, cur_addr=3, ctrl_ena=1.
REQ-037 Request addr=0 -> rst_n low pulse, no inc, done 7 cycles after acceptance.
REQ-038 FASTINC_EN with cur_addr=2: request 5 -> no rst_n pulse, 3 incs, done 15 cycles after acceptance; request 5 again -> done 3 cycles after acceptance; request 1 -> full path.
REQ-039 Hold req_valid during a sequence with a changing req_addr -> no second acceptance, cur_addr equals the first latched value.
REQ-040 Assert rst during INC_HI of addr=7 -> inc=0, ena=0 and rst_n=0 asynchronously; after release, INIT then IDLE with cur_addr=0.

Source files
------------

// File: rtl/tt_sel_seq.sv
// rtl/tt_sel_seq.sv - design-select sequencer: pulses selector reset/increment to reach a target address.
// Optional incremental fast path enabled by defining TT_SEL_SEQ_FASTINC_EN.
module tt_sel_seq #(
    parameter int ADDR_W   = 10,
    parameter int HALF_PER = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_DISABLE,
        ST_RST_LO,
        ST_RST_HI,
        ST_INC_HI,
        ST_INC_LO,
        ST_DONE
    } state_t;

    localparam logic [7:0] T_LAST = 8'(HALF_PER - 1);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        timer;
    logic              timer_done;
    logic              accept;
    logic [ADDR_W-1:0] addr_lat;
    logic [ADDR_W-1:0] n_rem;
    logic              ena_seen;

    assign timer_done = (timer == T_LAST);
    assign accept     = (state == ST_IDLE) && req_valid;

`ifdef TT_SEL_SEQ_FASTINC_EN
    logic              fast_path;
    logic              fast_ok;
    logic [ADDR_W-1:0] fast_n;

    // Subtraction only used when it cannot wrap.
    assign fast_ok = (req_addr >= cur_addr);
    assign fast_n  = req_addr - cur_addr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:    if (timer_done) state_nxt = ST_IDLE;
            ST_IDLE:    if (req_valid) state_nxt = ST_DISABLE;
            ST_DISABLE: begin
                if (timer_done) begin
`ifdef TT_SEL_SEQ_FASTINC_EN
                    if (fast_path) begin
                        state_nxt = (n_rem != '0) ? ST_INC_HI : ST_DONE;
                    end else begin
                        state_nxt = ST_RST_LO;
                    end
`else
                    state_nxt = ST_RST_LO;
`endif
                end
            end
            ST_RST_LO:  if (timer_done) state_nxt = ST_RST_HI;
            ST_RST_HI:  if (timer_done) state_nxt = (n_rem != '0) ? ST_INC_HI : ST_DONE;
            ST_INC_HI:  if (timer_done) state_nxt = ST_INC_LO;
            ST_INC_LO:  if (timer_done) state_nxt = (n_rem != '0) ? ST_INC_HI : ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        req_ready      = 1'b0;
        done           = 1'b0;
        busy           = 1'b1;
        ctrl_sel_rst_n = 1'b1;
        ctrl_sel_inc   = 1'b0;
        ctrl_ena       = 1'b0;
        case (state)
            ST_INIT:   ctrl_sel_rst_n = 1'b0;
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                ctrl_ena  = ena_seen;
            end
            ST_RST_LO: ctrl_sel_rst_n = 1'b0;
            ST_INC_HI: ctrl_sel_inc = 1'b1;
            ST_DONE: begin
                done     = 1'b1;
                ctrl_ena = 1'b1;
            end
            default: ;
        endcase
    end

    // Timer runs only in timed states and wraps exactly on each state exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: timer <= '0;
                default:          timer <= timer_done ? 8'd0 : timer + 8'd1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_lat  <= '0;
            n_rem     <= '0;
            cur_addr  <= '0;
            ena_seen  <= 1'b0;
`ifdef TT_SEL_SEQ_FASTINC_EN
            fast_path <= 1'b0;
`endif
        end else begin
            if (accept) begin
                addr_lat <= req_addr;
`ifdef TT_SEL_SEQ_FASTINC_EN
                fast_path <= fast_ok;
                n_rem     <= fast_ok ? fast_n : req_addr;
`else
                n_rem     <= req_addr;
`endif
            end
            if ((state == ST_INC_HI) && timer_done) begin
                n_rem <= n_rem - 1'b1;
            end
            if (state == ST_DONE) begin
                cur_addr <= addr_lat;
                ena_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tt_sel_seq.sv
// tb/tb_tt_sel_seq.sv - directed self-checking bench for tt_sel_seq (HALF_PER=2).
module tb_tt_sel_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [9:0] req_addr = '0;
    logic       done;
    logic       busy;
    logic [9:0] cur_addr;
    logic       ctrl_sel_rst_n;
    logic       ctrl_sel_inc;
    logic       ctrl_ena;

    int tests  = 0;
    int failed = 0;

    tt_sel_seq #(.ADDR_W(10), .HALF_PER(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .done(done), .busy(busy), .cur_addr(cur_addr),
        .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena)
    );

    always #5 clk = ~clk;

    // Issues one request from idle and records what the controller saw until done.
    task automatic do_req(input logic [9:0] a, input bit hold,
                          output int lat, output int incs, output int inc_hi,
                          output int rst_lo, output int ena_early, output int extra);
        bit prev_inc;
        lat = 0; incs = 0; inc_hi = 0; rst_lo = 0; ena_early = 0; extra = 0;
        prev_inc = 1'b0;
        for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
        if (!req_ready) return;
        req_valid = 1'b1;
        req_addr  = a;
        @(posedge clk);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
            if (req_ready && req_valid) extra++;
            if (hold) req_addr = 10'($urandom);
            if (ctrl_sel_inc) inc_hi++;
            if (ctrl_sel_inc && !prev_inc) incs++;
            prev_inc = ctrl_sel_inc;
            if (!ctrl_sel_rst_n) rst_lo++;
            if (ctrl_ena && !done) ena_early++;
            if (done) begin
                lat = c;
                break;
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int lo_cnt;
        #1;
        tests++; if (ctrl_sel_rst_n !== 1'b0) begin failed++; $display("FAIL rst_rst_n got=%b exp=0", ctrl_sel_rst_n); end
        tests++; if (ctrl_sel_inc !== 1'b0) begin failed++; $display("FAIL rst_inc got=%b exp=0", ctrl_sel_inc); end
        tests++; if (ctrl_ena !== 1'b0) begin failed++; $display("FAIL rst_ena got=%b exp=0", ctrl_ena); end
        tests++; if ({done, req_ready, busy} !== 3'b001) begin failed++; $display("FAIL rst_flags got=%b exp=001", {done, req_ready, busy}); end
        tests++; if (cur_addr !== 10'd0) begin failed++; $display("FAIL rst_cur got=%0d exp=0", cur_addr); end
        @(negedge clk);
        rst = 1'b0;
        lo_cnt = 0;
        #1;
        if (!ctrl_sel_rst_n && !req_ready) lo_cnt++;
        @(negedge clk);
        if (!ctrl_sel_rst_n && !req_ready) lo_cnt++;
        @(negedge clk);
        tests++; if (lo_cnt !== 2) begin failed++; $display("FAIL init_len got=%0d exp=2", lo_cnt); end
        tests++; if (req_ready !== 1'b1 || ctrl_sel_rst_n !== 1'b1) begin failed++; $display("FAIL init_ready got=%b%b exp=11", req_ready, ctrl_sel_rst_n); end
        tests++; if (cur_addr !== 10'd0 || ctrl_ena !== 1'b0) begin failed++; $display("FAIL init_idle cur=%0d ena=%b exp 0/0", cur_addr, ctrl_ena); end
    endtask

    task automatic run_check(input string name, input logic [9:0] a, input bit hold,
                             input int e_lat, input int e_incs, input int e_rstlo);
        int lat, incs, inc_hi, rst_lo, ena_early, extra;
        do_req(a, hold, lat, incs, inc_hi, rst_lo, ena_early, extra);
        tests++; if (lat !== e_lat) begin failed++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, e_lat); end
        tests++; if (incs !== e_incs || inc_hi !== 2 * e_incs) begin failed++; $display("FAIL %s_inc got=%0d/%0d exp=%0d/%0d", name, incs, inc_hi, e_incs, 2 * e_incs); end
        tests++; if (rst_lo !== e_rstlo) begin failed++; $display("FAIL %s_rst_lo got=%0d exp=%0d", name, rst_lo, e_rstlo); end
        tests++; if (ena_early !== 0) begin failed++; $display("FAIL %s_ena_busy got=%0d exp=0", name, ena_early); end
        tests++; if (extra !== 0) begin failed++; $display("FAIL %s_extra_accept got=%0d exp=0", name, extra); end
        tests++; if (cur_addr !== a || ctrl_ena !== 1'b1 || req_ready !== 1'b1) begin
            failed++; $display("FAIL %s_after cur=%0d ena=%b rdy=%b exp cur=%0d ena=1 rdy=1", name, cur_addr, ctrl_ena, req_ready, a);
        end
    endtask

    task automatic test_full_path();
        run_check("full3", 10'd3, 1'b0, 19, 3, 2);
    endtask

    task automatic test_zero();
        run_check("zero", 10'd0, 1'b0, 7, 0, 2);
    endtask

    task automatic test_fastinc();
`ifdef TT_SEL_SEQ_FASTINC_EN
        run_check("to2", 10'd2, 1'b0, 11, 2, 0);
        run_check("fast5", 10'd5, 1'b0, 15, 3, 0);
        run_check("same5", 10'd5, 1'b0, 3, 0, 0);
        run_check("down1", 10'd1, 1'b0, 11, 1, 2);
`else
        run_check("to2", 10'd2, 1'b0, 15, 2, 2);
        run_check("full5", 10'd5, 1'b0, 27, 5, 2);
        run_check("again5", 10'd5, 1'b0, 27, 5, 2);
        run_check("down1", 10'd1, 1'b0, 11, 1, 2);
`endif
    endtask

    task automatic test_hold_valid();
`ifdef TT_SEL_SEQ_FASTINC_EN
        run_check("hold4", 10'd4, 1'b1, 15, 3, 0);
`else
        run_check("hold4", 10'd4, 1'b1, 23, 4, 2);
`endif
    endtask

    task automatic test_async_reset();
        bit seen;
        for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 10'd7;
        @(negedge clk);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (ctrl_sel_inc) seen = 1'b1;
        end
        tests++; if (!seen) begin failed++; $display("FAIL arst_reach_inc got=0 exp=1"); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if ({ctrl_sel_inc, ctrl_ena, ctrl_sel_rst_n} !== 3'b000) begin failed++; $display("FAIL arst_ctrl got=%b exp=000", {ctrl_sel_inc, ctrl_ena, ctrl_sel_rst_n}); end
        tests++; if ({done, req_ready, busy} !== 3'b001 || cur_addr !== 10'd0) begin failed++; $display("FAIL arst_state flags=%b cur=%0d exp 001/0", {done, req_ready, busy}, cur_addr); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (ctrl_sel_rst_n !== 1'b0 || req_ready !== 1'b0) begin failed++; $display("FAIL arst_init got=%b%b exp=00", ctrl_sel_rst_n, req_ready); end
        @(negedge clk);
        @(negedge clk);
        tests++; if (req_ready !== 1'b1 || cur_addr !== 10'd0 || ctrl_ena !== 1'b0) begin failed++; $display("FAIL arst_idle rdy=%b cur=%0d ena=%b exp 1/0/0", req_ready, cur_addr, ctrl_ena); end
    endtask

    initial begin
        test_reset();
        test_full_path();
        test_zero();
        test_fastinc();
        test_hold_valid();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
